// File: rtl/burst_rd_engine.sv
// burst_rd_engine: strided SRAM burst reader streaming beats through a 2-entry credit-tracked buffer
module burst_rd_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN = 15,
  parameter int STRIDE_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0] issue_cnt, beat_cnt;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic [1:0] fifo_count;
  logic wr_ptr, rd_ptr, inflight, pop, accept, issue_last, beat_last;
  assign out_valid = fifo_count != 2'd0;
  assign out_data = fifo_mem[rd_ptr];
  assign pop = out_valid && out_ready;
  assign accept = req_ready && req_valid;
  assign issue_last = issue_cnt == CW'(BURST_LEN - 1);
  assign beat_last = beat_cnt == CW'(BURST_LEN - 1);
  assign out_last = out_valid && beat_last;
  assign sram_addr = addr_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state, handshake and credit-gated read strobe; a read is allowed only if the
  // buffer can still hold it after accounting for the in-flight word and this cycle's pop
  always_comb begin
    state_nxt = state;
    req_ready = state == IDLE;
    busy = state != IDLE;
    sram_rd_en = (state == ISSUE) && ({1'b0, fifo_count} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    if (accept) state_nxt = ISSUE;
    if (sram_rd_en && issue_last) state_nxt = DRAIN;
    if (state == DRAIN && pop && beat_last) state_nxt = IDLE;
  end
  // address walk, burst counters, in-flight tracking and completion pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      issue_cnt <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
      done <= 1'b0;
    end else begin
      inflight <= sram_rd_en;
      done <= state == DRAIN && pop && beat_last;
      if (accept) begin
        addr_q <= req_addr;
        issue_cnt <= '0;
        beat_cnt <= '0;
      end else begin
        if (sram_rd_en) begin
          addr_q <= addr_q + ADDR_WIDTH'(STRIDE_LEN);
          issue_cnt <= issue_cnt + CW'(1);
        end
        if (pop) beat_cnt <= beat_cnt + CW'(1);
      end
    end
  // 2-entry output buffer; returning SRAM data is pushed the cycle after its strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= sram_rdata;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
endmodule
